// File: rtl/cpu_inst_encoder.sv
// ============================================================================
// Module      : cpu_inst_encoder
// Description : Turns field-level encode requests into MIPS instruction words
//               on a valid/ready stream; expands li and branch delay slots.
//               Optional feature macro: CPU_ENCODER_DELAY_SLOT_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_inst_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_kind,
    input  logic [5:0]  req_opcode,
    input  logic [5:0]  req_funct,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_shamt,
    input  logic [31:0] req_imm,
    input  logic [25:0] req_jaddr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_last,
    output logic        err,
    output logic [15:0] word_count
);

    localparam logic [3:0] c_kind_rfmt = 4'd0;
    localparam logic [3:0] c_kind_ifmt = 4'd1;
    localparam logic [3:0] c_kind_jfmt = 4'd2;
    localparam logic [3:0] c_kind_li   = 4'd3;
    localparam logic [3:0] c_kind_move = 4'd4;
    localparam logic [3:0] c_kind_nop  = 4'd5;
    localparam logic [3:0] c_kind_br   = 4'd6;

    localparam logic [5:0] c_op_ori = 6'b001101;
    localparam logic [5:0] c_op_lui = 6'b001111;

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_second = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [31:0] r_pending;
    logic        r_out_valid;
    logic [31:0] r_out_inst;
    logic        r_out_last;
    logic        r_err;
    logic [15:0] r_word_count;

    logic [31:0] w_first;
    logic [31:0] w_second;
    logic        w_li_two;
    logic        w_illegal;
    logic        w_two;
    logic        w_accept;
    logic        w_consume;
    logic        w_load;

    always_comb begin
        w_first   = 32'h0000_0000;
        w_second  = 32'h0000_0000;
        w_li_two  = 1'b0;
        w_illegal = 1'b0;
        case (req_kind)
            c_kind_rfmt: w_first = {6'b000000, req_rs, req_rt, req_rd, req_shamt, req_funct};
            c_kind_ifmt,
            c_kind_br:   w_first = {req_opcode, req_rs, req_rt, req_imm[15:0]};
            c_kind_jfmt: w_first = {req_opcode, req_jaddr};
            c_kind_li: begin
                if (req_imm[31:16] == 16'h0000) begin
                    w_first = {c_op_ori, 5'd0, req_rt, req_imm[15:0]};
                end else begin
                    w_first = {c_op_lui, 5'd0, req_rt, req_imm[31:16]};
                    // Non-zero low half needs the follow-up ori on the same register
                    if (req_imm[15:0] != 16'h0000) begin
                        w_li_two = 1'b1;
                        w_second = {c_op_ori, req_rt, req_rt, req_imm[15:0]};
                    end
                end
            end
            c_kind_move: w_first = {6'b000000, req_rs, 5'd0, req_rd, 5'd0, 6'b100001};
            c_kind_nop:  w_first = 32'h0000_0000;
            default:     w_illegal = 1'b1;
        endcase
    end

`ifdef CPU_ENCODER_DELAY_SLOT_EN
    // Branch words are followed by a NOP, which is the default w_second value
    logic w_branch;
    assign w_branch = (req_kind == c_kind_jfmt) || (req_kind == c_kind_br) ||
                      ((req_kind == c_kind_rfmt) && (req_funct[5:1] == 5'b00100));
    assign w_two    = w_li_two | w_branch;
`else
    assign w_two    = w_li_two;
`endif

    assign req_ready = !rst && (r_state == c_st_idle) && (!r_out_valid || out_ready);
    assign w_accept  = req_valid && req_ready;
    assign w_consume = r_out_valid && out_ready;
    assign w_load    = w_accept && !w_illegal;

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_st_idle) begin
            if (w_load && w_two) w_state_nxt = c_st_second;
        end else begin
            if (w_consume) w_state_nxt = c_st_idle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending    <= 32'h0000_0000;
            r_out_valid  <= 1'b0;
            r_out_inst   <= 32'h0000_0000;
            r_out_last   <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= 16'h0000;
        end else begin
            r_err <= w_accept && w_illegal;
            if (w_consume) r_word_count <= r_word_count + 16'd1;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_inst  <= w_first;
                r_out_last  <= !w_two;
                if (w_two) r_pending <= w_second;
            end else if ((r_state == c_st_second) && w_consume) begin
                r_out_inst <= r_pending;
                r_out_last <= 1'b1;
            end else if (w_consume) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_inst   = r_out_inst;
    assign out_last   = r_out_last;
    assign err        = r_err;
    assign word_count = r_word_count;

endmodule

`default_nettype wire
